// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and constants for the bit-serial adder stage.
//   state_t       - FSM encoding (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH - default operand/sum width
package serial_add_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add_stage_fa_cell.sv
// fa_cell: combinational one-bit full adder used by the serial datapath.
// Ports:
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out (majority of the inputs)
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_stage.sv
// serial_add_stage: bit-serial adder. Operands are accepted over valid/ready,
// rippled LSB-first through a single full-adder cell with a registered carry
// (one bit per enabled clock), and the WIDTH-bit sum plus carry-out are
// presented downstream over valid/ready.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset (overrides ena)
//   ena                 : tile enable; low freezes every register
//   in_valid, in_ready  : operand handshake (a, b, cin)
//   out_valid, out_ready: result handshake (sum, cout)
//   busy                : high while bits are being shifted
//   ovf                 : signed overflow, present only with SERIAL_ADD_OVF_EN
//
// Optional feature macro: SERIAL_ADD_OVF_EN adds the ovf output.
module serial_add_stage
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
   output logic             ovf,
`endif
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t             state, state_n;
   logic [WIDTH-1:0]   sa, sb, res;
   logic               carry;
   logic [CNT_W-1:0]   cnt;
   logic               bit_s, bit_co;
   logic               last;

   fa_cell u_fa (
      .a  (sa[0]),
      .b  (sb[0]),
      .ci (carry),
      .s  (bit_s),
      .co (bit_co)
   );

   // Final bit is being processed this cycle.
   assign last = (cnt == CNT_W'(WIDTH - 1));

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (in_valid)  state_n = SHIFT;
         SHIFT:   if (last)      state_n = DONE;
         DONE:    if (out_ready) state_n = IDLE;
         default:                state_n = IDLE;
      endcase
   end

`ifdef SERIAL_ADD_OVF_EN
   logic ovf_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         res   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q <= 1'b0;
`endif
      end else if (ena) begin
         state <= state_n;
         case (state)
            IDLE: if (in_valid) begin
               sa    <= a;
               sb    <= b;
               carry <= cin;
               res   <= '0;
               cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
               ovf_q <= 1'b0;
`endif
            end
            SHIFT: begin
               // Sum bits enter at the MSB so after WIDTH shifts bit 0 is the LSB.
               res   <= {bit_s, res[WIDTH-1:1]};
               carry <= bit_co;
               sa    <= sa >> 1;
               sb    <= sb >> 1;
               cnt   <= cnt + CNT_W'(1);
`ifdef SERIAL_ADD_OVF_EN
               // Carry into the MSB vs carry out of the MSB.
               if (last) ovf_q <= carry ^ bit_co;
`endif
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == SHIFT);
   assign sum       = res;
   assign cout      = carry;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule
